// File: rtl/missile_pkg.sv
// Shared types and constants for the missile bus sequencer.
package missile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VID1,
        VID2,
        CPU
    } seq_state_t;

    localparam logic [15:0] RAM_TOP_DEFAULT = 16'h4000;
    localparam int unsigned PH_DECIDE       = 1;
    localparam int unsigned PH_CPU_FIRST    = 2;

endpackage

// File: rtl/missile_watchdog.sv
// Frame-count watchdog: fires a fixed-length reset pulse after too many unkicked vblanks.
module missile_watchdog #(
    parameter int unsigned WDOG_FRAMES = 8,
    parameter int unsigned WDOG_PULSE  = 16
) (
    input  logic clk_10M,
    input  logic reset_n,
    input  logic pause,
    input  logic vblank_start,
    input  logic wdog_clear,
    output logic wdog_reset
);

    localparam int unsigned FW = $clog2(WDOG_FRAMES + 1);
    localparam int unsigned PW = $clog2(WDOG_PULSE + 1);

    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] pulse_cnt;

    // Counting and kicks are both ignored while a pulse is in flight.
    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt  <= '0;
            pulse_cnt  <= '0;
            wdog_reset <= 1'b0;
        end else if (pulse_cnt != '0) begin
            pulse_cnt  <= pulse_cnt - PW'(1);
            wdog_reset <= (pulse_cnt > PW'(1));
            frame_cnt  <= '0;
        end else if (wdog_clear) begin
            frame_cnt <= '0;
        end else if (vblank_start && !pause) begin
            if (frame_cnt == FW'(WDOG_FRAMES - 1)) begin
                frame_cnt  <= '0;
                pulse_cnt  <= PW'(WDOG_PULSE);
                wdog_reset <= 1'b1;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/missile_bus_sequencer.sv
// CPU phase generator and shared-RAM arbiter (video priority, phi_0 stretch), plus watchdog.
module missile_bus_sequencer
    import missile_pkg::*;
#(
    parameter int unsigned DIV         = 8,
    parameter int unsigned MAX_STRETCH = 4,
    parameter logic [15:0] RAM_TOP     = RAM_TOP_DEFAULT,
    parameter int unsigned WDOG_FRAMES = 8,
    parameter int unsigned WDOG_PULSE  = 16
) (
    input  logic        clk_10M,
    input  logic        reset_n,
    input  logic        pause,
    input  logic        vblank_start,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        wdog_clear,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic        s_phi_x,
    output logic        s_phi_extend,
    output logic [13:0] ram_addr,
    output logic        ram_sel_vid,
    output logic        ram_we_n,
    output logic        vid_ack,
    output logic        wdog_reset
);

    localparam int unsigned PHW = $clog2(DIV);
    localparam int unsigned SW  = $clog2(MAX_STRETCH + 1);

    localparam logic [PHW-1:0] PH_LAST     = PHW'(DIV - 1);
    localparam logic [PHW-1:0] PH_HALF     = PHW'(DIV / 2);
    localparam logic [PHW-1:0] PH_CPU_LAST = PHW'(DIV / 2 - 1);
    localparam logic [PHW-1:0] PH_DEC      = PHW'(PH_DECIDE);
    localparam logic [PHW-1:0] PH_CPU_LO   = PHW'(PH_CPU_FIRST);

    seq_state_t     state, state_nx;
    logic [PHW-1:0] ph_cnt, ph_nx;
    logic [SW-1:0]  stretch_cnt;
    logic           cpu_pend, pend_nx, pend_now;
    logic           decide, cap, freeze;

    // Next-state: the CPU slot is claimed once per cycle at the decision phase.
    always_comb begin
        decide   = (ph_cnt == PH_DEC) && !cpu_pend && (state != CPU);
        pend_now = cpu_pend || (decide && (cpu_addr < RAM_TOP));
        cap      = (stretch_cnt >= SW'(MAX_STRETCH));
        state_nx = state;
        pend_nx  = pend_now;
        case (state)
            IDLE: begin
                if (pend_now && (cap || !vid_req)) begin
                    state_nx = CPU;
                    pend_nx  = 1'b0;
                end else if (vid_req) begin
                    state_nx = VID1;
                end
            end
            VID1: state_nx = VID2;
            VID2: begin
                if (pend_now) begin
                    state_nx = CPU;
                    pend_nx  = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            CPU: begin
                if (ph_cnt >= PH_CPU_LAST) state_nx = vid_req ? VID1 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Phase holds at the decision point while a waiting CPU is locked out by video.
        freeze = pend_nx && ((state_nx == VID1) || (state_nx == VID2));
        if (freeze)                 ph_nx = ph_cnt;
        else if (ph_cnt == PH_LAST) ph_nx = '0;
        else                        ph_nx = ph_cnt + PHW'(1);
    end

    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            cpu_pend     <= 1'b0;
            stretch_cnt  <= '0;
            s_phi_x      <= 1'b0;
            s_phi_extend <= 1'b0;
            ram_addr     <= '0;
            ram_sel_vid  <= 1'b0;
            ram_we_n     <= 1'b1;
            vid_ack      <= 1'b0;
        end else begin
            state    <= state_nx;
            ph_cnt   <= ph_nx;
            cpu_pend <= pend_nx;
            if (ph_cnt == PH_LAST && !freeze) stretch_cnt <= '0;
            else if (freeze && !cap)          stretch_cnt <= stretch_cnt + SW'(1);
            s_phi_x      <= (ph_nx < PH_HALF);
            s_phi_extend <= freeze;
            ram_sel_vid  <= (state_nx == VID1) || (state_nx == VID2);
            vid_ack      <= (state_nx == VID2);
            ram_we_n     <= !((state_nx == CPU) && (ph_nx >= PH_CPU_LO) &&
                              (ph_nx < PH_HALF) && !cpu_rw);
            if (state_nx == VID1)     ram_addr <= vid_addr;
            else if (state_nx == CPU) ram_addr <= cpu_addr[13:0];
        end
    end

    missile_watchdog #(
        .WDOG_FRAMES (WDOG_FRAMES),
        .WDOG_PULSE  (WDOG_PULSE)
    ) u_watchdog (
        .clk_10M      (clk_10M),
        .reset_n      (reset_n),
        .pause        (pause),
        .vblank_start (vblank_start),
        .wdog_clear   (wdog_clear),
        .wdog_reset   (wdog_reset)
    );

endmodule

// File: tb/tb_missile_bus_sequencer.sv
// Directed bench for missile_bus_sequencer: per-clock vector table plus watchdog/stress sequences.
module tb_missile_bus_sequencer;

    localparam int unsigned MAX_STRETCH = 4;

    logic        clk_10M = 1'b0;
    logic        reset_n;
    logic        pause;
    logic        vblank_start;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        wdog_clear;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        s_phi_x;
    logic        s_phi_extend;
    logic [13:0] ram_addr;
    logic        ram_sel_vid;
    logic        ram_we_n;
    logic        vid_ack;
    logic        wdog_reset;

    missile_bus_sequencer dut (
        .clk_10M      (clk_10M),
        .reset_n      (reset_n),
        .pause        (pause),
        .vblank_start (vblank_start),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .wdog_clear   (wdog_clear),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .s_phi_x      (s_phi_x),
        .s_phi_extend (s_phi_extend),
        .ram_addr     (ram_addr),
        .ram_sel_vid  (ram_sel_vid),
        .ram_we_n     (ram_we_n),
        .vid_ack      (vid_ack),
        .wdog_reset   (wdog_reset)
    );

    always #50 clk_10M = ~clk_10M;

    // Observed bus: {phi_x, extend, sel_vid, we_n, ack, addr}
    logic [18:0] obs;
    assign obs = {s_phi_x, s_phi_extend, ram_sel_vid, ram_we_n, vid_ack, ram_addr};
    localparam logic [18:0] RST_OBS = {5'b00010, 14'h0000};

    typedef struct {
        logic        vid_req;
        logic [13:0] vid_addr;
        logic [15:0] cpu_addr;
        logic        cpu_rw;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input logic vr, input logic [13:0] va, input logic [15:0] ca,
                                input logic rw, input logic [4:0] flags, input logic [13:0] addr);
        vec_t v;
        v.vid_req  = vr;
        v.vid_addr = va;
        v.cpu_addr = ca;
        v.cpu_rw   = rw;
        v.exp      = {flags, addr};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic vbl(input logic kick);
        vblank_start = 1'b1;
        wdog_clear   = kick;
        @(negedge clk_10M);
        vblank_start = 1'b0;
        wdog_clear   = 1'b0;
    endtask

    // Counts high samples of wdog_reset, trying a kick partway through.
    task automatic measure_pulse(output int len);
        len = 0;
        while (wdog_reset === 1'b1 && len < 40) begin
            len++;
            wdog_clear = (len == 3);
            @(negedge clk_10M);
        end
        wdog_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rises, falls, run, max_run, acks, len;
        logic prev_phi, prev_we, found;

        n_vec = 0; n_bad = 0;
        reset_n = 1'b0; pause = 1'b0; vblank_start = 1'b0; wdog_clear = 1'b0;
        cpu_addr = 16'hFFFF; cpu_rw = 1'b1; vid_req = 1'b0; vid_addr = '0;

        // flags = {phi_x, extend, sel_vid, we_n, ack}
        // CPU write 0x1234
        tbl.push_back(mk(1'b0, 14'h0000, 16'h1234, 1'b0, 5'b10010, 14'h0000));
        tbl.push_back(mk(1'b0, 14'h0000, 16'h1234, 1'b0, 5'b10000, 14'h1234));
        tbl.push_back(mk(1'b0, 14'h0000, 16'h1234, 1'b0, 5'b10000, 14'h1234));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 14'h0000, 16'h1234, 1'b0, 5'b00010, 14'h1234));
        tbl.push_back(mk(1'b0, 14'h0000, 16'h1234, 1'b0, 5'b10010, 14'h1234));
        // Video fetch in low phase, no CPU need
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 14'h0ABC, 16'hFFFF, 1'b1, 5'b10010, 14'h1234));
        tbl.push_back(mk(1'b0, 14'h0ABC, 16'hFFFF, 1'b1, 5'b00010, 14'h1234));
        tbl.push_back(mk(1'b1, 14'h0ABC, 16'hFFFF, 1'b1, 5'b00110, 14'h0ABC));
        tbl.push_back(mk(1'b1, 14'h0ABC, 16'hFFFF, 1'b1, 5'b00111, 14'h0ABC));
        tbl.push_back(mk(1'b0, 14'h0ABC, 16'hFFFF, 1'b1, 5'b00010, 14'h0ABC));
        tbl.push_back(mk(1'b0, 14'h0ABC, 16'hFFFF, 1'b1, 5'b10010, 14'h0ABC));
        // Video and CPU read collide at the decision point: two stretch clocks
        tbl.push_back(mk(1'b0, 14'h0155, 16'h0100, 1'b1, 5'b10010, 14'h0ABC));
        tbl.push_back(mk(1'b1, 14'h0155, 16'h0100, 1'b1, 5'b11110, 14'h0155));
        tbl.push_back(mk(1'b1, 14'h0155, 16'h0100, 1'b1, 5'b11111, 14'h0155));
        tbl.push_back(mk(1'b0, 14'h0155, 16'h0100, 1'b1, 5'b10010, 14'h0100));
        tbl.push_back(mk(1'b0, 14'h0155, 16'h0100, 1'b1, 5'b10010, 14'h0100));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 14'h0155, 16'h0100, 1'b1, 5'b00010, 14'h0100));
        tbl.push_back(mk(1'b0, 14'h0155, 16'h0100, 1'b1, 5'b10010, 14'h0100));
        // CPU write at top RAM address; video waits out the CPU window
        tbl.push_back(mk(1'b0, 14'h0222, 16'h3FFF, 1'b0, 5'b10010, 14'h0100));
        tbl.push_back(mk(1'b0, 14'h0222, 16'h3FFF, 1'b0, 5'b10000, 14'h3FFF));
        tbl.push_back(mk(1'b1, 14'h0222, 16'h3FFF, 1'b0, 5'b10000, 14'h3FFF));
        tbl.push_back(mk(1'b1, 14'h0222, 16'h3FFF, 1'b0, 5'b00110, 14'h0222));
        tbl.push_back(mk(1'b1, 14'h0222, 16'h3FFF, 1'b0, 5'b00111, 14'h0222));
        tbl.push_back(mk(1'b0, 14'h0222, 16'h3FFF, 1'b0, 5'b00010, 14'h0222));
        tbl.push_back(mk(1'b0, 14'h0222, 16'h3FFF, 1'b0, 5'b00010, 14'h0222));
        tbl.push_back(mk(1'b0, 14'h0222, 16'h3FFF, 1'b0, 5'b10010, 14'h0222));
        // Address 0x4000 is outside shared RAM: no access
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 14'h0222, 16'h4000, 1'b0, 5'b10010, 14'h0222));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 14'h0222, 16'h4000, 1'b0, 5'b00010, 14'h0222));
        tbl.push_back(mk(1'b0, 14'h0222, 16'h4000, 1'b0, 5'b10010, 14'h0222));
        // Video starts just before the decision point: one stretch clock
        tbl.push_back(mk(1'b1, 14'h0333, 16'h0010, 1'b1, 5'b10110, 14'h0333));
        tbl.push_back(mk(1'b1, 14'h0333, 16'h0010, 1'b1, 5'b11111, 14'h0333));
        tbl.push_back(mk(1'b0, 14'h0333, 16'h0010, 1'b1, 5'b10010, 14'h0010));
        tbl.push_back(mk(1'b0, 14'h0333, 16'h0010, 1'b1, 5'b10010, 14'h0010));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 14'h0333, 16'h0010, 1'b1, 5'b00010, 14'h0010));
        tbl.push_back(mk(1'b0, 14'h0333, 16'h0010, 1'b1, 5'b10010, 14'h0010));

        repeat (2) @(negedge clk_10M);
        check("reset_outputs", 32'(obs), 32'(RST_OBS));
        check("reset_wdog", 32'(wdog_reset), 32'(0));
        reset_n = 1'b1;

        // Free run: phi_x is 4 high / 4 low, no stretch, no writes
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_10M);
            check($sformatf("freerun_%0d", i), 32'({s_phi_x, s_phi_extend, ram_we_n}),
                  32'({((i % 8) < 4), 1'b0, 1'b1}));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            vid_req  = tbl[i].vid_req;
            vid_addr = tbl[i].vid_addr;
            cpu_addr = tbl[i].cpu_addr;
            cpu_rw   = tbl[i].cpu_rw;
            @(negedge clk_10M);
            check($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
        end

        // Continuous video demand plus a CPU RAM write every cycle
        vid_req = 1'b1; vid_addr = 14'h0444; cpu_addr = 16'h0200; cpu_rw = 1'b0;
        prev_phi = s_phi_x; prev_we = ram_we_n;
        rises = 0; falls = 0; run = 0; max_run = 0; acks = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_10M);
            if (s_phi_x && !prev_phi) rises++;
            if (!ram_we_n && prev_we) falls++;
            run = s_phi_extend ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (vid_ack) acks++;
            prev_phi = s_phi_x;
            prev_we  = ram_we_n;
        end
        check("stress_cycles", 32'(rises >= 5), 32'(1));
        check("stress_cpu_every_cycle", 32'(falls >= rises - 1), 32'(1));
        check("stress_extend_cap", 32'(max_run <= MAX_STRETCH && max_run > 0), 32'(1));
        check("stress_video_served", 32'(acks >= rises - 1), 32'(1));

        // Async reset in the middle of a CPU write
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_10M);
            if (!ram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        check("midreset_find_write", 32'(found), 32'(1));
        #10 reset_n = 1'b0;
        #1 check("midreset_outputs", 32'(obs), 32'(RST_OBS));
        vid_req = 1'b0; cpu_addr = 16'hFFFF; cpu_rw = 1'b1;
        @(negedge clk_10M);
        reset_n = 1'b1;
        @(negedge clk_10M);

        // Watchdog: eight unkicked frames fire a 16-clock pulse
        repeat (7) vbl(1'b0);
        @(negedge clk_10M);
        check("wd_seven_frames", 32'(wdog_reset), 32'(0));
        vbl(1'b0);
        check("wd_fire", 32'(wdog_reset), 32'(1));
        measure_pulse(len);
        check("wd_pulse_len", 32'(len), 32'(16));

        // Kick on the eighth vblank wins and restarts the count
        repeat (7) vbl(1'b0);
        vbl(1'b1);
        @(negedge clk_10M);
        check("wd_kick_on_eighth", 32'(wdog_reset), 32'(0));
        repeat (7) vbl(1'b0);
        check("wd_after_kick_seven", 32'(wdog_reset), 32'(0));
        vbl(1'b0);
        check("wd_fire_after_kick", 32'(wdog_reset), 32'(1));
        measure_pulse(len);
        check("wd_pulse_len2", 32'(len), 32'(16));

        // Pause freezes the frame count
        repeat (4) vbl(1'b0);
        pause = 1'b1;
        repeat (10) vbl(1'b0);
        pause = 1'b0;
        @(negedge clk_10M);
        check("wd_pause_hold", 32'(wdog_reset), 32'(0));
        repeat (3) vbl(1'b0);
        check("wd_seven_with_pause", 32'(wdog_reset), 32'(0));
        vbl(1'b0);
        check("wd_fire_after_pause", 32'(wdog_reset), 32'(1));
        measure_pulse(len);
        check("wd_pulse_len3", 32'(len), 32'(16));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
